pwm_axil_slave: RTL and testbench

- AXI4-Lite slave front-end for the multi-channel PWM register file.
- Terminates AXI4-Lite write and read channels from the interconnect.
- Converts them into single-cycle decoded strobes: write_en/write_addr/write_data and read_en/read_addr.
- Captures the register file's registered read_data/read_valid response and returns it as an AXI R beat with an OKAY or SLVERR response.

---
 rtl/pwm_pkg.sv | 14 +
 rtl/pwm_axil_slave.sv | 129 ++++++++++++
 tb/tb_pwm_axil_slave.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// pwm_pkg: shared response codes, register map indices and FSM states for the PWM AXI4-Lite slave
package pwm_pkg;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam int PRESCALE_IDX = 0;
  function automatic int period_idx(input int ch);
    return 1 + 2 * ch;
  endfunction
  function automatic int duty_idx(input int ch);
    return 2 + 2 * ch;
  endfunction
  typedef enum logic [1:0] {W_IDLE, W_EXEC, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_WAIT, R_RESP} r_state_t;
endpackage

// File: rtl/pwm_axil_slave.sv
// pwm_axil_slave: AXI4-Lite slave turning AW/W/AR traffic into one-cycle register-file strobes
module pwm_axil_slave
  import pwm_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 8,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int REG_WIDTH = 16,
  parameter int NUM_CHANNELS = 4,
  localparam int DEPTH = 1 + 2 * NUM_CHANNELS,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [AXI_ADDR_WIDTH-1:0]   s_awaddr,
  input  logic                        s_awvalid,
  output logic                        s_awready,
  input  logic [AXI_DATA_WIDTH-1:0]   s_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0] s_wstrb,
  input  logic                        s_wvalid,
  output logic                        s_wready,
  output logic [1:0]                  s_bresp,
  output logic                        s_bvalid,
  input  logic                        s_bready,
  input  logic [AXI_ADDR_WIDTH-1:0]   s_araddr,
  input  logic                        s_arvalid,
  output logic                        s_arready,
  output logic [AXI_DATA_WIDTH-1:0]   s_rdata,
  output logic [1:0]                  s_rresp,
  output logic                        s_rvalid,
  input  logic                        s_rready,
  output logic                        write_en,
  output logic [ADDR_WIDTH-1:0]       write_addr,
  output logic [REG_WIDTH-1:0]        write_data,
  output logic                        read_en,
  output logic [ADDR_WIDTH-1:0]       read_addr,
  input  logic [REG_WIDTH-1:0]        read_data,
  input  logic                        read_valid
);
  // The word index plus every address bit above it must stay below DEPTH.
  function automatic logic in_range(input logic [AXI_ADDR_WIDTH-1:0] a);
    return (a >> 2) < AXI_ADDR_WIDTH'(DEPTH);
  endfunction
  w_state_t w_state, w_next;
  r_state_t r_state, r_next;
  logic aw_held, w_held, aw_hs, w_hs, ar_hs, aw_now, w_now, w_start, w_ok, unused_bits;
  logic [AXI_ADDR_WIDTH-1:0] aw_q, cur_addr;
  logic [REG_WIDTH-1:0] wdata_q, cur_data;
  logic [REG_WIDTH/8-1:0] wstrb_q, cur_strb;
  assign aw_hs = s_awvalid && s_awready;
  assign w_hs = s_wvalid && s_wready;
  assign ar_hs = s_arvalid && s_arready;
  assign unused_bits = ^{s_wdata, s_wstrb};
  always_comb begin
    aw_now = aw_held || aw_hs;
    w_now = w_held || w_hs;
    cur_addr = aw_held ? aw_q : s_awaddr;
    cur_data = w_held ? wdata_q : s_wdata[REG_WIDTH-1:0];
    cur_strb = w_held ? wstrb_q : s_wstrb[REG_WIDTH/8-1:0];
    w_ok = in_range(cur_addr) && &cur_strb;
    w_start = w_state == W_IDLE && aw_now && w_now;
    w_next = w_state == W_IDLE ? (w_start ? W_EXEC : W_IDLE) :
             w_state == W_EXEC ? W_RESP :
             (s_bvalid && s_bready ? W_IDLE : W_RESP);
    r_next = r_state == R_IDLE  ? (ar_hs ? (in_range(s_araddr) ? R_ISSUE : R_RESP) : R_IDLE) :
             r_state == R_ISSUE ? R_WAIT :
             r_state == R_WAIT  ? (read_valid ? R_RESP : R_WAIT) :
             (s_rvalid && s_rready ? R_IDLE : R_RESP);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w_state <= W_IDLE;
      aw_held <= 1'b0;
      w_held <= 1'b0;
      aw_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      s_awready <= 1'b0;
      s_wready <= 1'b0;
      s_bvalid <= 1'b0;
      s_bresp <= RESP_OKAY;
      write_en <= 1'b0;
      write_addr <= '0;
      write_data <= '0;
    end else begin
      w_state <= w_next;
      aw_held <= w_next == W_IDLE && aw_now;
      w_held <= w_next == W_IDLE && w_now;
      if (aw_hs) aw_q <= s_awaddr;
      if (w_hs) begin
        wdata_q <= s_wdata[REG_WIDTH-1:0];
        wstrb_q <= s_wstrb[REG_WIDTH/8-1:0];
      end
      s_awready <= w_next == W_IDLE && !aw_now;
      s_wready <= w_next == W_IDLE && !w_now;
      s_bvalid <= w_next == W_RESP;
      write_en <= w_start && w_ok;
      if (w_start) s_bresp <= w_ok ? RESP_OKAY : RESP_SLVERR;
      if (w_start && w_ok) begin
        write_addr <= cur_addr[ADDR_WIDTH+1:2];
        write_data <= cur_data;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= R_IDLE;
      s_arready <= 1'b0;
      s_rvalid <= 1'b0;
      s_rresp <= RESP_OKAY;
      s_rdata <= '0;
      read_en <= 1'b0;
      read_addr <= '0;
    end else begin
      r_state <= r_next;
      s_arready <= r_next == R_IDLE;
      s_rvalid <= r_next == R_RESP;
      read_en <= r_next == R_ISSUE;
      if (r_next == R_ISSUE) read_addr <= s_araddr[ADDR_WIDTH+1:2];
      if (ar_hs && r_next == R_RESP) begin
        s_rresp <= RESP_SLVERR;
        s_rdata <= '0;
      end
      if (r_state == R_WAIT && read_valid) begin
        s_rresp <= RESP_OKAY;
        s_rdata <= AXI_DATA_WIDTH'(read_data);
      end
    end
  end
endmodule

// File: tb/tb_pwm_axil_slave.sv
// tb_pwm_axil_slave: directed AXI4-Lite transactions against a register-file stand-in and a map-level model
module tb_pwm_axil_slave;
  import pwm_pkg::*;
  localparam int DEPTH = 9;
  logic clk = 0, rst_n = 0;
  logic [7:0] s_awaddr = 0, s_araddr = 0;
  logic s_awvalid = 0, s_wvalid = 0, s_bready = 0, s_arvalid = 0, s_rready = 0;
  logic [31:0] s_wdata = 0;
  logic [3:0] s_wstrb = 0;
  logic s_awready, s_wready, s_bvalid, s_arready, s_rvalid, write_en, read_en;
  logic [1:0] s_bresp, s_rresp;
  logic [31:0] s_rdata;
  logic [3:0] write_addr, read_addr;
  logic [15:0] write_data;
  logic [15:0] read_data = 0;
  logic read_valid = 0;
  int cyc = 0, checks = 0, errors = 0;
  typedef struct {int c; logic [3:0] idx; logic [15:0] data;} ev_t;
  ev_t exp_w[$], exp_r[$];
  logic [15:0] model [16];
  logic [15:0] mem [16];

  pwm_axil_slave dut (
    .clk(clk), .rst_n(rst_n),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .write_en(write_en), .write_addr(write_addr), .write_data(write_data),
    .read_en(read_en), .read_addr(read_addr), .read_data(read_data), .read_valid(read_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Register file stand-in: one-cycle registered read that returns the pre-write value.
  initial begin
    logic pend;
    logic [15:0] pdat;
    for (int i = 0; i < 16; i++) mem[i] = 0;
    forever begin
      @(negedge clk);
      pend = read_en;
      pdat = mem[read_addr];
      if (write_en) mem[write_addr] = write_data;
      @(posedge clk);
      #1;
      read_valid = pend;
      read_data = pdat;
    end
  end

  // Per-cycle compare: strobes against expected events, response stability and blocking.
  initial begin
    logic p_ok, p_bv, p_br, p_rv, p_rr, due_w, due_r;
    logic [1:0] p_bresp, p_rresp;
    logic [31:0] p_rdata;
    p_ok = 0; p_bv = 0; p_br = 0; p_rv = 0; p_rr = 0; p_bresp = 0; p_rresp = 0; p_rdata = 0;
    forever begin
      @(negedge clk);
      if (p_ok && rst_n && p_bv && !p_br) chk("b_hold", {s_bvalid, s_bresp}, {1'b1, p_bresp});
      if (p_ok && rst_n && p_rv && !p_rr) chk("r_hold", {s_rvalid, s_rresp, s_rdata}, {1'b1, p_rresp, p_rdata});
      if (s_bvalid) chk("aw_w_blocked", {s_awready, s_wready}, 2'b00);
      if (s_rvalid) chk("ar_blocked", s_arready, 0);
      due_w = exp_w.size() > 0 && exp_w[0].c == cyc;
      if (write_en || due_w) chk("write_en", write_en, due_w);
      if (write_en && due_w) chk("write_strobe", {write_addr, write_data}, {exp_w[0].idx, exp_w[0].data});
      if (due_w) void'(exp_w.pop_front());
      due_r = exp_r.size() > 0 && exp_r[0].c == cyc;
      if (read_en || due_r) chk("read_en", read_en, due_r);
      if (read_en && due_r) chk("read_addr", read_addr, exp_r[0].idx);
      if (due_r) void'(exp_r.pop_front());
      p_ok = rst_n; p_bv = s_bvalid; p_br = s_bready; p_bresp = s_bresp;
      p_rv = s_rvalid; p_rr = s_rready; p_rresp = s_rresp; p_rdata = s_rdata;
    end
  end

  task automatic write_req(input logic [7:0] addr, input logic [15:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, output int hs);
    int ha, hw;
    ha = 0;
    hw = 0;
    fork
      begin
        repeat (aw_dly) begin @(posedge clk); #1; end
        s_awaddr = addr;
        s_awvalid = 1;
        for (int i = 0; i < 50 && ha == 0; i++) begin @(negedge clk); if (s_awready) ha = cyc + 1; end
        @(posedge clk);
        #1 s_awvalid = 0;
      end
      begin
        repeat (w_dly) begin @(posedge clk); #1; end
        s_wdata = {16'hDEAD, data};
        s_wstrb = strb;
        s_wvalid = 1;
        for (int i = 0; i < 50 && hw == 0; i++) begin @(negedge clk); if (s_wready) hw = cyc + 1; end
        @(posedge clk);
        #1 s_wvalid = 0;
      end
    join
    chk("aw_handshake", ha != 0, 1);
    chk("w_handshake", hw != 0, 1);
    hs = ha > hw ? ha : hw;
    if (addr < 4 * DEPTH && strb[1:0] == 2'b11) begin
      model[addr[5:2]] = data;
      exp_w.push_back('{c: hs, idx: addr[5:2], data: data});
    end
  endtask

  task automatic write_resp(input int hs, input logic [1:0] exp, input int dly);
    int first;
    first = 0;
    for (int i = 0; i < 50 && first == 0; i++) begin @(negedge clk); if (s_bvalid) first = cyc; end
    chk("b_latency", first, hs + 1);
    repeat (dly) @(negedge clk);
    chk("bresp", s_bresp, exp);
    @(posedge clk);
    #1 s_bready = 1;
    @(posedge clk);
    #1 s_bready = 0;
    chk("b_done", s_bvalid, 0);
  endtask

  task automatic read_req(input logic [7:0] addr, output int hs);
    hs = 0;
    s_araddr = addr;
    s_arvalid = 1;
    for (int i = 0; i < 50 && hs == 0; i++) begin @(negedge clk); if (s_arready) hs = cyc + 1; end
    @(posedge clk);
    #1 s_arvalid = 0;
    chk("ar_handshake", hs != 0, 1);
    if (addr < 4 * DEPTH) exp_r.push_back('{c: hs, idx: addr[5:2], data: 0});
  endtask

  task automatic read_resp(input logic [7:0] addr, input int hs, input logic [1:0] exp_resp,
                           input logic [31:0] exp_data, input int dly);
    int first;
    first = 0;
    for (int i = 0; i < 50 && first == 0; i++) begin @(negedge clk); if (s_rvalid) first = cyc; end
    chk("r_latency", first, addr < 4 * DEPTH ? hs + 2 : hs);
    repeat (dly) @(negedge clk);
    chk("rresp", s_rresp, exp_resp);
    chk("rdata", s_rdata, exp_data);
    @(posedge clk);
    #1 s_rready = 1;
    @(posedge clk);
    #1 s_rready = 0;
    chk("r_done", s_rvalid, 0);
  endtask

  task automatic do_write(input logic [7:0] addr, input logic [15:0] data, input logic [3:0] strb,
                          input int aw_dly, input int w_dly, input logic [1:0] exp, input int dly);
    int hs;
    write_req(addr, data, strb, aw_dly, w_dly, hs);
    write_resp(hs, exp, dly);
  endtask

  task automatic do_read(input logic [7:0] addr, input logic [1:0] exp_resp, input logic [31:0] exp_data,
                         input int dly);
    int hs;
    read_req(addr, hs);
    read_resp(addr, hs, exp_resp, exp_data, dly);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int hw, hr;
    for (int i = 0; i < 16; i++) model[i] = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ctrl", {s_awready, s_wready, s_arready, s_bvalid, s_rvalid, write_en, read_en, s_bresp, s_rresp}, 0);
    chk("rst_data", {s_rdata, write_addr, write_data, read_addr}, 0);
    @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    chk("rdy_still_low", {s_awready, s_wready, s_arready}, 0);
    @(negedge clk);
    chk("rdy_after_rst", {s_awready, s_wready, s_arready}, 3'b111);
    @(posedge clk);
    #1;
    do_write(8'h00, 16'h1234, 4'hF, 0, 0, RESP_OKAY, 0);
    do_write(8'(4 * period_idx(0)), 16'hBEEF, 4'hF, 3, 0, RESP_OKAY, 0);
    do_write(8'h24, 16'h0055, 4'hF, 0, 0, RESP_SLVERR, 0);
    do_write(8'h08, 16'h0077, 4'b0001, 0, 0, RESP_SLVERR, 0);
    do_write(8'(4 * duty_idx(0)), 16'h00C8, 4'hF, 0, 0, RESP_OKAY, 0);
    do_read(8'h08, RESP_OKAY, 32'h000000C8, 0);
    do_read(8'h30, RESP_SLVERR, 32'h0, 0);
    do_read(8'h04, RESP_OKAY, 32'h0000BEEF, 5);
    do_read(8'(4 * PRESCALE_IDX + 3), RESP_OKAY, 32'h00001234, 0);
    do_write(8'h1C, 16'hA5A5, 4'b0011, 0, 2, RESP_OKAY, 5);
    do_read(8'h1C, RESP_OKAY, {16'h0, model[7]}, 0);
    do_read(8'h40, RESP_SLVERR, 32'h0, 0);
    do_write(8'h20, 16'h0F0F, 4'hF, 1, 0, RESP_OKAY, 0);
    do_read(8'h20, RESP_OKAY, {16'h0, model[8]}, 0);
    do_write(8'h0C, 16'h2222, 4'hF, 0, 0, RESP_OKAY, 0);
    fork
      do_write(8'h0C, 16'h1111, 4'hF, 0, 0, RESP_OKAY, 0);
      do_read(8'h0C, RESP_OKAY, 32'h00002222, 0);
    join
    do_read(8'h0C, RESP_OKAY, 32'h00001111, 0);
    write_req(8'h10, 16'h3333, 4'hF, 0, 0, hw);
    read_req(8'h10, hr);
    @(posedge clk);
    #1 rst_n = 0;
    @(negedge clk);
    chk("pre_rst_pending", {s_bvalid, s_rvalid}, 2'b10);
    @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    chk("rst_mid_txn", {s_bvalid, s_rvalid, write_en, read_en, s_awready, s_wready, s_arready}, 0);
    @(negedge clk);
    chk("rdy_after_rst2", {s_awready, s_wready, s_arready}, 3'b111);
    @(posedge clk);
    #1;
    do_write(8'h10, 16'h4444, 4'hF, 0, 0, RESP_OKAY, 0);
    do_read(8'h10, RESP_OKAY, 32'h00004444, 0);
    repeat (3) @(posedge clk);
    chk("exp_w_drained", exp_w.size(), 0);
    chk("exp_r_drained", exp_r.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
